// File: rtl/chanels_collector.sv
// rtl/chanels_collector.sv - gathers one (ac, ph) result per channel into a frame and streams it out in channel order.
module chanels_collector #(
  parameter int CHANELS = 4,
  parameter int AW      = $clog2(CHANELS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_vld,
  input  logic [AW-1:0] i_addres,
  input  logic [31:0]   i_ac,
  input  logic [31:0]   i_ph,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [AW-1:0] o_addres,
  output logic [31:0]   o_ac,
  output logic [31:0]   o_ph,
  output logic          o_last,
  output logic          o_ovf
);

  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    SEND     = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(CHANELS - 1);

  logic [0:0]         state;
  logic [CHANELS-1:0] mask;
  logic [CHANELS-1:0] mask_nxt;
  logic [31:0]        cap_ac [CHANELS];
  logic [31:0]        cap_ph [CHANELS];
  logic [31:0]        snd_ac [CHANELS];
  logic [31:0]        snd_ph [CHANELS];
  logic               wr_en;
  logic               swap;
  logic [AW-1:0]      next_idx;

  assign wr_en    = i_vld && (int'(i_addres) < CHANELS);
  assign swap     = (state == IDLE) && (&mask);
  assign next_idx = o_addres + 1'b1;
  assign o_vld    = (state == SEND);

  // A write landing in the swap cycle starts the next frame, so the cleared mask gets its bit.
  always_comb begin
    mask_nxt = swap ? '0 : mask;
    if (wr_en) begin
      mask_nxt[i_addres] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask  <= '0;
      o_ovf <= 1'b0;
    end else begin
      if (wr_en && mask[i_addres] && !swap) begin
        o_ovf <= 1'b1;
      end
      mask <= mask_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < CHANELS; k++) begin
        cap_ac[k] <= '0;
        cap_ph[k] <= '0;
        snd_ac[k] <= '0;
        snd_ph[k] <= '0;
      end
    end else begin
      if (wr_en) begin
        cap_ac[i_addres] <= i_ac;
        cap_ph[i_addres] <= i_ph;
      end
      if (swap) begin
        for (int k = 0; k < CHANELS; k++) begin
          snd_ac[k] <= cap_ac[k];
          snd_ph[k] <= cap_ph[k];
        end
      end
    end
  end

  // Output word 0 comes straight from the capture bank at the swap edge; later words from the send bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      o_addres <= '0;
      o_ac     <= '0;
      o_ph     <= '0;
      o_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (swap) begin
            state    <= SEND;
            o_addres <= '0;
            o_ac     <= cap_ac[0];
            o_ph     <= cap_ph[0];
            o_last   <= 1'b0;
          end
        end
        SEND: begin
          if (i_rdy) begin
            if (o_addres == LAST_IDX) begin
              state  <= IDLE;
              o_last <= 1'b0;
            end else begin
              o_addres <= next_idx;
              o_ac     <= snd_ac[next_idx];
              o_ph     <= snd_ph[next_idx];
              o_last   <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chanels_collector.sv
// tb/tb_chanels_collector.sv - frame-queue reference model plus directed and random stimulus for chanels_collector.
module tb_chanels_collector;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_vld = 1'b0;
  logic [1:0]  i_addres = '0;
  logic [31:0] i_ac = '0;
  logic [31:0] i_ph = '0;
  logic        i_rdy = 1'b1;
  logic        o_vld, o_last, o_ovf;
  logic [1:0]  o_addres;
  logic [31:0] o_ac, o_ph;

  logic        v3 = 1'b0;
  logic [1:0]  a3 = '0;
  logic [31:0] ac3 = '0;
  logic        rdy3 = 1'b1;
  logic        o3_vld, o3_last, o3_ovf;
  logic [1:0]  o3_addres;
  logic [31:0] o3_ac, o3_ph;

  int checks = 0;
  int failures = 0;

  chanels_collector #(.CHANELS(4)) dut (
    .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_addres(i_addres), .i_ac(i_ac), .i_ph(i_ph),
    .o_vld(o_vld), .i_rdy(i_rdy), .o_addres(o_addres), .o_ac(o_ac), .o_ph(o_ph),
    .o_last(o_last), .o_ovf(o_ovf)
  );

  chanels_collector #(.CHANELS(3)) dut3 (
    .clk(clk), .rstn(rstn), .i_vld(v3), .i_addres(a3), .i_ac(ac3), .i_ph(32'h0),
    .o_vld(o3_vld), .i_rdy(rdy3), .o_addres(o3_addres), .o_ac(o3_ac), .o_ph(o3_ph),
    .o_last(o3_last), .o_ovf(o3_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] nph(input int c);
    return 32'(-c);
  endfunction

  // Reference: completed frames become a queue of words once the previous frame has drained.
  typedef struct {
    logic [1:0]  addr;
    logic [31:0] ac;
    logic [31:0] ph;
  } word_t;

  word_t       out_q[$];
  logic [31:0] m_ac[4];
  logic [31:0] m_ph[4];
  bit          written[4];
  bit          m_ovf;
  bit          m_full;
  bit          m_swap;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q.delete();
      for (int k = 0; k < 4; k++) begin
        written[k] = 1'b0;
        m_ac[k] = '0;
        m_ph[k] = '0;
      end
      m_ovf = 1'b0;
    end else begin
      m_full = 1'b1;
      for (int k = 0; k < 4; k++) if (!written[k]) m_full = 1'b0;
      m_swap = m_full && (out_q.size() == 0);
      if (out_q.size() > 0 && i_rdy) void'(out_q.pop_front());
      if (m_swap) begin
        for (int k = 0; k < 4; k++) begin
          out_q.push_back('{addr: 2'(k), ac: m_ac[k], ph: m_ph[k]});
          written[k] = 1'b0;
        end
      end
      if (i_vld) begin
        if (written[i_addres]) m_ovf = 1'b1;
        m_ac[i_addres] = i_ac;
        m_ph[i_addres] = i_ph;
        written[i_addres] = 1'b1;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (!rstn) begin
      chk("rst_ctl", {o_vld, o_last, o_ovf, o_addres}, 0);
      chk("rst_ac", o_ac, 0);
      chk("rst_ph", o_ph, 0);
    end else begin
      chk("vld", o_vld, out_q.size() > 0);
      chk("ovf", o_ovf, m_ovf);
      if (out_q.size() > 0) begin
        chk("addr", o_addres, out_q[0].addr);
        chk("ac", o_ac, out_q[0].ac);
        chk("ph", o_ph, out_q[0].ph);
        chk("last", o_last, out_q[0].addr == 2'd3);
      end
    end
  end

  task automatic cyc(input bit v, input int a, input logic [31:0] ac, input logic [31:0] ph);
    @(negedge clk);
    i_vld = v;
    i_addres = 2'(a);
    i_ac = ac;
    i_ph = ph;
  endtask

  task automatic cyc3(input bit v, input int a, input logic [31:0] ac);
    @(negedge clk);
    v3 = v;
    a3 = 2'(a);
    ac3 = ac;
  endtask

  int ord[4] = '{2, 0, 3, 1};
  int seen_addr[$];
  logic [31:0] seen_ac[$];
  logic [31:0] seen_ph[$];
  bit exp_v;
  bit found;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Basic frame, out-of-order writes, ready always high.
    i_rdy = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1, ord[k], 32'h10 + ord[k], nph(ord[k]));
    cyc(0, 0, 0, 0);
    chk("s1_vld_early", o_vld, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0);
      chk("s1_vld", o_vld, 1);
      chk("s1_addr", o_addres, k);
      chk("s1_ac", o_ac, 32'h10 + k);
      chk("s1_ph", o_ph, nph(k));
      chk("s1_last", o_last, k == 3);
    end
    cyc(0, 0, 0, 0);
    chk("s1_vld_end", o_vld, 0);
    chk("s1_ovf", o_ovf, 0);

    // Same frame under a 1,0,0,1 ready pattern.
    for (int c = 0; c < 20; c++) begin
      if (c < 4) cyc(1, ord[c], 32'h10 + ord[c], nph(ord[c]));
      else cyc(0, 0, 0, 0);
      i_rdy = (c % 4 == 0) || (c % 4 == 3);
      if (o_vld && i_rdy) begin
        seen_addr.push_back(int'(o_addres));
        seen_ac.push_back(o_ac);
        seen_ph.push_back(o_ph);
      end
    end
    i_rdy = 1'b1;
    chk("s2_count", seen_addr.size(), 4);
    for (int k = 0; k < 4 && k < seen_addr.size(); k++) begin
      chk("s2_addr", seen_addr[k], k);
      chk("s2_ac", seen_ac[k], 32'h10 + k);
      chk("s2_ph", seen_ph[k], nph(k));
    end

    // Frame B captured while frame A is stalled; B follows after one idle cycle.
    i_rdy = 1'b0;
    for (int ch = 0; ch < 4; ch++) cyc(1, ch, 32'hA0 + ch, ch);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int ch = 0; ch < 4; ch++) cyc(1, ch, 32'hB0 + ch, 32'h100 + ch);
    cyc(0, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      cyc(0, 0, 0, 0);
      i_rdy = 1'b1;
      exp_v = (c < 4) || (c >= 5 && c < 9);
      chk("s4_vld", o_vld, exp_v);
      if (exp_v) chk("s4_ac", o_ac, (c < 4) ? 32'hA0 + c : 32'hB0 + c - 5);
    end

    // Write to ch3 in the swap cycle belongs to the next frame.
    for (int ch = 0; ch < 4; ch++) cyc(1, ch, 32'hC0 + ch, 0);
    cyc(1, 3, 32'hD3, 0);
    cyc(0, 0, 0, 0);
    chk("swp_mask", dut.mask, 4'b1000);
    chk("swp_vld", o_vld, 1);
    chk("swp_ac0", o_ac, 32'hC0);
    for (int k = 1; k < 4; k++) begin
      cyc(0, 0, 0, 0);
      chk("swp_ac", o_ac, 32'hC0 + k);
    end
    chk("swp_ovf", o_ovf, 0);
    for (int ch = 0; ch < 3; ch++) cyc(1, ch, 32'hD0 + ch, 0);
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0);
      chk("nxt_ac", o_ac, 32'hD0 + k);
    end
    cyc(0, 0, 0, 0);

    // Overwrite of channel 0 before the frame completes.
    cyc(1, 0, 32'd5, 0);
    cyc(1, 0, 32'd7, 0);
    cyc(1, 1, 32'd1, 0);
    chk("s3_ovf_set", o_ovf, 1);
    cyc(1, 2, 32'd2, 0);
    cyc(1, 3, 32'd3, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("s3_vld", o_vld, 1);
    chk("s3_ac0", o_ac, 32'd7);
    repeat (4) cyc(0, 0, 0, 0);
    chk("s3_vld_end", o_vld, 0);
    chk("s3_ovf_sticky", o_ovf, 1);

    // Reset in the middle of a frame.
    for (int ch = 0; ch < 4; ch++) cyc(1, ch, 32'hE0 + ch, 0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc(0, 0, 0, 0);
      if (o_vld && o_addres == 2'd2) found = 1'b1;
    end
    chk("s5_reach", found, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("s5_rst_ctl", {o_vld, o_last, o_ovf, o_addres}, 0);
    chk("s5_rst_ac", o_ac, 0);
    chk("s5_rst_ph", o_ph, 0);
    rstn = 1'b1;
    for (int ch = 0; ch < 3; ch++) cyc(1, ch, 32'hF0 + ch, 0);
    for (int c = 0; c < 5; c++) begin
      cyc(0, 0, 0, 0);
      chk("s5_no_vld", o_vld, 0);
    end
    cyc(1, 3, 32'hF3, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("s5_vld", o_vld, 1);
    chk("s5_ac0", o_ac, 32'hF0);
    repeat (4) cyc(0, 0, 0, 0);

    // Three-channel instance ignores address 3.
    cyc3(1, 3, 32'h33);
    cyc3(1, 0, 32'h30);
    cyc3(1, 3, 32'h34);
    cyc3(1, 1, 32'h31);
    for (int c = 0; c < 4; c++) begin
      cyc3(0, 0, 0);
      chk("c3_no_vld", o3_vld, 0);
      chk("c3_no_ovf", o3_ovf, 0);
    end
    cyc3(1, 2, 32'h32);
    cyc3(0, 0, 0);
    chk("c3_vld_early", o3_vld, 0);
    for (int k = 0; k < 3; k++) begin
      cyc3(0, 0, 0);
      chk("c3_vld", o3_vld, 1);
      chk("c3_addr", o3_addres, k);
      chk("c3_ac", o3_ac, 32'h30 + k);
      chk("c3_last", o3_last, k == 2);
    end
    cyc3(0, 0, 0);
    chk("c3_vld_end", o3_vld, 0);
    chk("c3_ovf", o3_ovf, 0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      i_vld = (c < 1500) ? ($urandom % 4 != 0) : ($urandom % 3 == 0);
      i_addres = 2'($urandom);
      i_ac = $urandom;
      i_ph = $urandom;
      i_rdy = ($urandom % 4 != 0);
      if ($urandom % 600 == 0) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
    end
    @(negedge clk);
    i_vld = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
